gelato_inst_buffer: RTL and testbench

Per-warp instruction buffer (I-Buffer). It is the receiving end of gelato_idecode_ibuffer_if and accepts one decoded instruction per cycle from the instruction decode stage. Entries are held in one circular FIFO per warp and popped in order by the issue/scheduler stage. Per-warp empty/full masks go back to the warp scheduler so fetch throttles itself.

---
 rtl/gelato_types.sv | 19 +
 rtl/gelato_idecode_ibuffer_if.sv | 15 +
 rtl/gelato_ibuffer_fifo.sv | 55 +++++
 rtl/gelato_inst_buffer.sv | 72 +++++++
 tb/tb_gelato_inst_buffer.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/gelato_types.sv
// gelato_types: shared pipeline types for the gelato core, including instruction-buffer entries.
package gelato_types;
  localparam int NUM_THREADS = 8;
  localparam int IBUFFER_DEPTH = 4;
  localparam int IBUFFER_PC_WIDTH = 32;
  typedef logic [NUM_THREADS-1:0] thread_mask_t;
  typedef struct packed {
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [31:0] imm;
  } inst_t;
  typedef struct packed {
    logic [IBUFFER_PC_WIDTH-1:0] pc;
    thread_mask_t thread_mask;
    inst_t inst;
  } ibuffer_entry_t;
endpackage

// File: rtl/gelato_idecode_ibuffer_if.sv
// gelato_idecode_ibuffer_if: decode-to-ibuffer handoff, one decoded instruction per cycle.
interface gelato_idecode_ibuffer_if
  import gelato_types::*;
#(
  parameter int PC_WIDTH = IBUFFER_PC_WIDTH,
  parameter int NUM_WARPS = 4
);
  logic valid;
  logic [PC_WIDTH-1:0] pc;
  logic [$clog2(NUM_WARPS)-1:0] warp_num;
  thread_mask_t thread_mask;
  inst_t inst;
  modport master (output valid, pc, warp_num, thread_mask, inst);
  modport slave (input valid, pc, warp_num, thread_mask, inst);
endinterface

// File: rtl/gelato_ibuffer_fifo.sv
// gelato_ibuffer_fifo: single-warp circular FIFO; flush applies before a same-cycle push.
module gelato_ibuffer_fifo
  import gelato_types::*;
#(
  parameter int DEPTH = IBUFFER_DEPTH,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           push,
  input  logic           pop,
  input  logic           flush,
  input  ibuffer_entry_t wdata,
  output ibuffer_entry_t head,
  output logic [CW-1:0]  count,
  output logic           empty,
  output logic           full,
  output logic           drop
);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);
  ibuffer_entry_t mem [DEPTH];
  logic [CW-1:0] wptr, rptr, wbase, rbase, cbase;
  logic do_push, do_pop;
  function automatic logic [CW-1:0] inc(input logic [CW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction
  always_comb begin
    wbase = flush ? '0 : wptr;
    rbase = flush ? '0 : rptr;
    cbase = flush ? '0 : count;
    do_pop = pop && !flush && count != '0;
    // a pop frees a slot, so a full FIFO still takes a same-cycle push
    do_push = push && (cbase != FULL_CNT || do_pop);
    drop = push && !do_push;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      wptr <= do_push ? inc(wbase) : wbase;
      rptr <= do_pop ? inc(rbase) : rbase;
      count <= cbase + CW'(do_push) - CW'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem[wbase[AW-1:0]] <= wdata;
  end
  assign head = mem[rptr[AW-1:0]];
  assign empty = count == '0;
  assign full = count == FULL_CNT;
endmodule

// File: rtl/gelato_inst_buffer.sv
// gelato_inst_buffer: per-warp instruction buffer with registered in-order issue.
// Define GELATO_IBUFFER_BYPASS_EN to serve a pop of an empty warp from a same-cycle write.
module gelato_inst_buffer
  import gelato_types::*;
#(
  parameter int NUM_WARPS = 4,
  parameter int DEPTH = IBUFFER_DEPTH,
  parameter int PC_WIDTH = IBUFFER_PC_WIDTH,
  localparam int WW = $clog2(NUM_WARPS),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rdy,
  gelato_idecode_ibuffer_if.slave  inst_decoded_data,
  input  logic                     flush_valid,
  input  logic [WW-1:0]            flush_warp,
  input  logic                     issue_req,
  input  logic [WW-1:0]            issue_warp,
  output logic                     issue_valid,
  output logic [PC_WIDTH-1:0]      issue_pc,
  output logic [WW-1:0]            issue_warp_num,
  output thread_mask_t             issue_thread_mask,
  output inst_t                    issue_inst,
  output logic [NUM_WARPS-1:0]     empty_mask,
  output logic [NUM_WARPS-1:0]     full_mask,
  output logic                     overflow
);
  ibuffer_entry_t wr_entry, issue_entry;
  ibuffer_entry_t heads [NUM_WARPS];
  logic [CW-1:0] counts [NUM_WARPS];
  logic [NUM_WARPS-1:0] push, pop, flush, drop;
  logic same_flush, pop_ok, byp;
  assign wr_entry = '{pc: inst_decoded_data.pc, thread_mask: inst_decoded_data.thread_mask,
                      inst: inst_decoded_data.inst};
  assign same_flush = flush_valid && flush_warp == issue_warp;
  assign pop_ok = rdy && issue_req && !same_flush && counts[issue_warp] != '0;
`ifdef GELATO_IBUFFER_BYPASS_EN
  assign byp = rdy && issue_req && !same_flush && inst_decoded_data.valid &&
               inst_decoded_data.warp_num == issue_warp && counts[issue_warp] == '0;
`else
  assign byp = 1'b0;
`endif
  for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
    assign push[w] = rdy && inst_decoded_data.valid && inst_decoded_data.warp_num == WW'(w) && !byp;
    assign pop[w] = rdy && issue_req && issue_warp == WW'(w);
    assign flush[w] = rdy && flush_valid && flush_warp == WW'(w);
    gelato_ibuffer_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk(clk), .rst_n(rst_n), .push(push[w]), .pop(pop[w]), .flush(flush[w]),
      .wdata(wr_entry), .head(heads[w]), .count(counts[w]),
      .empty(empty_mask[w]), .full(full_mask[w]), .drop(drop[w])
    );
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_valid <= 1'b0;
      issue_entry <= '0;
      issue_warp_num <= '0;
      overflow <= 1'b0;
    end else if (rdy) begin
      issue_valid <= pop_ok || byp;
      if (pop_ok || byp) begin
        issue_entry <= byp ? wr_entry : heads[issue_warp];
        issue_warp_num <= issue_warp;
      end
      overflow <= overflow || |drop;
    end
  end
  assign issue_pc = issue_entry.pc;
  assign issue_thread_mask = issue_entry.thread_mask;
  assign issue_inst = issue_entry.inst;
endmodule

// File: tb/tb_gelato_inst_buffer.sv
// tb_gelato_inst_buffer: directed self-checking bench for gelato_inst_buffer.
module tb_gelato_inst_buffer;
  import gelato_types::*;
  logic clk = 0, rst_n = 0, rdy = 1;
  logic flush_valid = 0, issue_req = 0;
  logic [1:0] flush_warp = 0, issue_warp = 0;
  logic issue_valid, overflow;
  logic [31:0] issue_pc;
  logic [1:0] issue_warp_num;
  thread_mask_t issue_thread_mask;
  inst_t issue_inst;
  logic [3:0] empty_mask, full_mask;
  int checks = 0, failures = 0;

  gelato_idecode_ibuffer_if #(.PC_WIDTH(32), .NUM_WARPS(4)) dec_if ();

  gelato_inst_buffer #(.NUM_WARPS(4), .DEPTH(4), .PC_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .inst_decoded_data(dec_if),
    .flush_valid(flush_valid), .flush_warp(flush_warp),
    .issue_req(issue_req), .issue_warp(issue_warp),
    .issue_valid(issue_valid), .issue_pc(issue_pc), .issue_warp_num(issue_warp_num),
    .issue_thread_mask(issue_thread_mask), .issue_inst(issue_inst),
    .empty_mask(empty_mask), .full_mask(full_mask), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic thread_mask_t tm_of(input logic [31:0] pc);
    return pc[9:2] ^ 8'h5A;
  endfunction

  function automatic inst_t inst_of(input logic [31:0] pc);
    return '{opcode: pc[6:0], rd: pc[8:4], rs1: 5'd3, rs2: 5'd7, imm: ~pc};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic v, input logic [1:0] wn, input logic [31:0] pc,
                     input logic ir, input logic [1:0] iw, input logic fv, input logic [1:0] fw);
    dec_if.valid = v;
    dec_if.warp_num = wn;
    dec_if.pc = pc;
    dec_if.thread_mask = tm_of(pc);
    dec_if.inst = inst_of(pc);
    issue_req = ir;
    issue_warp = iw;
    flush_valid = fv;
    flush_warp = fw;
    @(posedge clk);
    #1;
    dec_if.valid = 0;
    issue_req = 0;
    flush_valid = 0;
  endtask

  task automatic wr(input logic [1:0] w, input logic [31:0] pc);
    cyc(1, w, pc, 0, 0, 0, 0);
  endtask

  task automatic pop_chk(input string tag, input logic [1:0] w, input logic [31:0] pc);
    cyc(0, 0, 0, 1, w, 0, 0);
    chk({tag, "_valid"}, 64'(issue_valid), 64'd1);
    chk({tag, "_pc"}, 64'(issue_pc), 64'(pc));
  endtask

  task automatic do_reset();
    rst_n = 0;
    #3;
    chk("rst_valid", 64'(issue_valid), 64'd0);
    chk("rst_empty", 64'(empty_mask), 64'hF);
    chk("rst_full", 64'(full_mask), 64'h0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_pc", 64'(issue_pc), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  initial begin
    dec_if.valid = 0;
    dec_if.warp_num = 0;
    dec_if.pc = 0;
    dec_if.thread_mask = 0;
    dec_if.inst = '0;
    @(posedge clk);
    #1;
    do_reset();

    for (int i = 0; i < 4; i++) wr(1, 32'h100 + 32'(4 * i));
    chk("w1_full", 64'(full_mask), 64'h2);
    chk("w1_empty", 64'(empty_mask), 64'hD);
    pop_chk("w1_p0", 1, 32'h100);
    chk("w1_p0_warp", 64'(issue_warp_num), 64'd1);
    chk("w1_p0_mask", 64'(issue_thread_mask), 64'(tm_of(32'h100)));
    chk("w1_p0_inst", 64'(issue_inst), 64'(inst_of(32'h100)));
    pop_chk("w1_p1", 1, 32'h104);
    pop_chk("w1_p2", 1, 32'h108);
    pop_chk("w1_p3", 1, 32'h10C);
    chk("w1_drained", 64'(empty_mask), 64'hF);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("idle_valid", 64'(issue_valid), 64'd0);

    for (int i = 0; i < 4; i++) wr(0, 32'h10 + 32'(4 * i));
    chk("w0_full", 64'(full_mask), 64'h1);
    chk("w0_ovf_pre", 64'(overflow), 64'd0);
    wr(0, 32'h200);
    chk("w0_ovf", 64'(overflow), 64'd1);
    for (int i = 0; i < 4; i++) pop_chk("w0_pop", 0, 32'h10 + 32'(4 * i));
    chk("w0_empty", 64'(empty_mask), 64'hF);
    chk("w0_ovf_sticky", 64'(overflow), 64'd1);

    do_reset();
    for (int i = 0; i < 4; i++) wr(2, 32'h30 + 32'(4 * i));
    cyc(1, 2, 32'h300, 1, 2, 0, 0);
    chk("w2_wp_valid", 64'(issue_valid), 64'd1);
    chk("w2_wp_pc", 64'(issue_pc), 64'h30);
    chk("w2_wp_full", 64'(full_mask), 64'h4);
    chk("w2_wp_ovf", 64'(overflow), 64'd0);
    pop_chk("w2_p1", 2, 32'h34);
    pop_chk("w2_p2", 2, 32'h38);
    pop_chk("w2_p3", 2, 32'h3C);
    pop_chk("w2_p4", 2, 32'h300);
    chk("w2_empty", 64'(empty_mask), 64'hF);

    wr(3, 32'h40);
    wr(3, 32'h44);
    cyc(1, 3, 32'h400, 1, 3, 1, 3);
    chk("w3_flush_valid", 64'(issue_valid), 64'd0);
    chk("w3_flush_empty", 64'(empty_mask), 64'h7);
    pop_chk("w3_after", 3, 32'h400);
    chk("w3_empty", 64'(empty_mask), 64'hF);

    cyc(0, 0, 0, 1, 1, 0, 0);
    chk("w1_empty_pop", 64'(issue_valid), 64'd0);
    cyc(1, 1, 32'h500, 1, 1, 0, 0);
`ifdef GELATO_IBUFFER_BYPASS_EN
    chk("byp_valid", 64'(issue_valid), 64'd1);
    chk("byp_pc", 64'(issue_pc), 64'h500);
    chk("byp_empty", 64'(empty_mask), 64'hF);
`else
    chk("nobyp_valid", 64'(issue_valid), 64'd0);
    chk("nobyp_empty", 64'(empty_mask), 64'hD);
    pop_chk("nobyp_pop", 1, 32'h500);
`endif

    cyc(1, 0, 32'h700, 1, 2, 0, 0);
    chk("indep_valid", 64'(issue_valid), 64'd0);
    chk("indep_empty", 64'(empty_mask), 64'hE);
    wr(0, 32'h704);
    pop_chk("rdy_pre", 0, 32'h700);
    rdy = 0;
    issue_req = 1;
    issue_warp = 0;
    dec_if.valid = 1;
    dec_if.warp_num = 0;
    dec_if.pc = 32'h7FF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("frz_valid", 64'(issue_valid), 64'd1);
      chk("frz_pc", 64'(issue_pc), 64'h700);
      chk("frz_empty", 64'(empty_mask), 64'hE);
    end
    dec_if.valid = 0;
    rdy = 1;
    @(posedge clk);
    #1;
    issue_req = 0;
    chk("thaw_valid", 64'(issue_valid), 64'd1);
    chk("thaw_pc", 64'(issue_pc), 64'h704);
    chk("thaw_empty", 64'(empty_mask), 64'hF);

    wr(2, 32'h800);
    wr(2, 32'h804);
    pop_chk("mid_pop", 2, 32'h800);
    #2;
    rst_n = 0;
    #1;
    chk("mid_rst_valid", 64'(issue_valid), 64'd0);
    chk("mid_rst_empty", 64'(empty_mask), 64'hF);
    chk("mid_rst_pc", 64'(issue_pc), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
